// File: rtl/xor8_rr_arbiter.sv
// Round-robin arbiter that time-shares one 8-bit XOR among NUM_REQ requesters
// and returns each result, tagged with the requester index, on one response port.

module xor_gate_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module xor8_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt_id;
  logic [7:0]     r_op_a;
  logic [7:0]     r_op_b;
  logic           r_rsp_valid;
  logic [7:0]     r_rsp_data;
  logic [IDW-1:0] r_rsp_id;

  logic           w_any;
  logic [IDW-1:0] w_winner;
  logic [7:0]     w_sel_a;
  logic [7:0]     w_sel_b;
  logic [7:0]     w_xor;

  // Scan from the farthest candidate down to ptr+1 so the nearest valid one wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = IDW'(idx);
        w_sel_a  = req_a[8*idx +: 8];
        w_sel_b  = req_b[8*idx +: 8];
      end
    end
  end

  // The grant is gated by rst so it drops immediately while reset is held.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_any && !rst)
      req_ready[w_winner] = 1'b1;
  end

  xor_gate_8bit u_xor (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_y (w_xor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_gnt_id    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_gnt_id <= w_winner;
            r_ptr    <= w_winner;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= w_xor;
          r_rsp_id    <= r_gnt_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);

endmodule
